regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- Read-side bridge for the 8-entry, 32-bit register file.
- On a start pulse, walks a register range through one regfile read port and snapshots each register.
- Serializes the dump as a byte stream with a valid/ready handshake, for scan-out through the TinyTapeout output pins.
- Stream order: header byte, then 4 little-endian bytes per register, then an XOR checksum byte.

Parameters:
- HDR_BYTE, 8'hA5, constant value of the first byte of every dump.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a dump; sampled only in IDLE.
- first_reg  input  3  first register index of the range, latched on accepted start.
- last_reg  input  3  last register index of the range, latched on accepted start.
- rf_ra  output  3  regfile read address.
- rf_rd  input  32  regfile read data; combinational, r0 reads as zero.
- tx_data  output  8  stream byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts a byte; a transfer occurs when tx_valid && tx_ready at a rising edge.
- busy  output  1  high from the cycle after an accepted start until the checksum transfers.
- done  output  1  one-cycle pulse in the cycle after the checksum transfers.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, tx_valid=0, tx_data=0, busy=0, done=0, rf_ra=0, checksum=0, byte counter=0.
- Reset mid-dump: abort immediately to IDLE. No further bytes are sent and no done pulse is issued.
- States: IDLE, HDR, LOAD, DATA, CSUM.
- IDLE:
  - tx_valid=0.
  - start=1 latches first_reg/last_reg, sets cur=first_reg, clears the checksum, then goes to HDR.
  - Latency: start sampled at edge t gives tx_valid=1 with the header after edge t.
- HDR:
  - tx_data=HDR_BYTE, tx_valid=1.
  - On transfer, go to LOAD.
- LOAD (1 cycle):
  - tx_valid=0, rf_ra=cur.
  - Capture rf_rd into a 32-bit shift register, byte counter=0, go to DATA.
  - Snapshot semantics: regfile writes after this edge do not alter the bytes of this register.
- DATA:
  - tx_data=shift[7:0], tx_valid=1.
  - On transfer: checksum ^= tx_data.
  - If the byte counter is below 3: shift right by 8 and increment the counter.
  - If the byte counter is 3 and cur==last: go to CSUM.
  - If the byte counter is 3 and cur!=last: cur=cur+1 (mod 8), go to LOAD.
- CSUM:
  - tx_data=checksum, tx_valid=1.
  - On transfer: go to IDLE and pulse done in the next cycle.
  - The checksum covers data bytes only, not the header.
- Range rules:
  - Register count N = ((last-first) mod 8)+1.
  - first>last wraps through 7 to 0 (e.g. 6..1 dumps 6, 7, 0, 1).
  - first==last dumps one register.
  - Total bytes = 4N+2; a full dump of 0..7 is 34 bytes.
- r0 is dumped as 4 zero bytes (the regfile returns zero for it).
- Handshake:
  - Once tx_valid rises, tx_data and tx_valid hold stable until the transfer.
  - tx_valid never drops without a transfer, except on reset.
  - tx_ready is ignored when tx_valid=0.
- start while busy is ignored; no queuing.
- rf_ra holds cur in all non-IDLE states. It is a register, with no combinational path from inputs.
- Throughput: with tx_ready held high, each register takes 5 cycles (LOAD plus 4 DATA).

Test Plan:
- Basic dump: regs r1=32'h11223344, r2=32'hDEADBEEF; start with first=1, last=2; tx_ready=1.
  - Required stream: A5, 44, 33, 22, 11, EF, BE, AD, DE, then checksum 8'h44^33^22^11^EF^BE^AD^DE.
  - Then done=1 for exactly one cycle, and busy=0.
- Backpressure: same dump with tx_ready toggling in a pseudo-random pattern (about 50%).
  - Required: identical byte sequence; tx_data stable whenever tx_valid && !tx_ready.
  - No byte is dropped or duplicated.
- Wrap and r0: first=7, last=0, r7=32'h00000080.
  - Required stream: A5, 80, 00, 00, 00, 00, 00, 00, 00, checksum 80; 10 bytes total.
- Full dump and snapshot: first=0, last=7.
  - Required: 34 bytes.
  - A regfile write to r5 after r5's LOAD does not change the r5 bytes; a write to r6 before r6's LOAD does appear in the stream.
- Start while busy and reset mid-dump:
  - A start pulse during DATA has no effect on the stream.
  - Asserting rst during the 3rd data byte gives tx_valid=0 and busy=0 next cycle, and no done pulse.
  - A new start then produces a fresh A5 header with the checksum restarted from 0.

Source files
------------

// File: rtl/regfile_dump.sv
// Read-side dump bridge: walks a register range through one regfile read port
// and streams header, little-endian register bytes and an XOR checksum.
module regfile_dump #(
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  first_reg,
  input  logic [2:0]  last_reg,
  output logic [2:0]  rf_ra,
  input  logic [31:0] rf_rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_DATA,
    S_CSUM
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cur_q, cur_d;
  logic [2:0]  last_q, last_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        done_q, done_d;

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    done_d   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = first_reg;
          last_d  = last_reg;
          csum_d  = 8'h00;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        tx_data  = HDR_BYTE;
        tx_valid = 1'b1;
        if (tx_ready) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Snapshot the whole word so later regfile writes cannot tear it.
        shift_d = rf_rd;
        cnt_d   = 2'd0;
        state_d = S_DATA;
      end
      S_DATA: begin
        tx_data  = shift_q[7:0];
        tx_valid = 1'b1;
        if (tx_ready) begin
          csum_d = csum_q ^ shift_q[7:0];
          if (cnt_q != 2'd3) begin
            shift_d = {8'h00, shift_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
          end else if (cur_q == last_q) begin
            state_d = S_CSUM;
          end else begin
            cur_d   = cur_q + 3'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_CSUM: begin
        tx_data  = csum_q;
        tx_valid = 1'b1;
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= 3'd0;
      last_q  <= 3'd0;
      shift_q <= 32'h0;
      cnt_q   <= 2'd0;
      csum_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
    end
  end

  assign rf_ra = cur_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: expected bytes are queued when a dump is
// started and compared as the stream transfers them.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  first_reg;
  logic [2:0]  last_reg;
  logic [2:0]  rf_ra;
  logic [31:0] rf_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [8];
  logic [7:0]  exp_q [$];
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  int          rx_cnt = 0;
  bit          rnd_ready = 1'b0;
  bit          hold_prev = 1'b0;
  logic [7:0]  hold_data;

  regfile_dump #(.HDR_BYTE(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .first_reg(first_reg),
    .last_reg (last_reg),
    .rf_ra    (rf_ra),
    .rf_rd    (rf_rd),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Regfile model: combinational read, r0 hardwired to zero.
  assign rf_rd = (rf_ra == 3'd0) ? 32'h0 : rf[rf_ra];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_dump(input logic [2:0] f, input logic [2:0] l, input logic [31:0] img [8]);
    logic [7:0]  cs = 8'h00;
    logic [2:0]  r  = f;
    logic [2:0]  span = l - f;
    logic [31:0] word;
    logic [7:0]  b;
    exp_q.push_back(8'hA5);
    for (int n = 0; n <= int'(span); n++) begin
      word = (r == 3'd0) ? 32'h0 : img[r];
      for (int k = 0; k < 4; k++) begin
        b = word[8*k +: 8];
        exp_q.push_back(b);
        cs ^= b;
      end
      r = r + 3'd1;
    end
    exp_q.push_back(cs);
  endtask

  task automatic start_dump(input logic [2:0] f, input logic [2:0] l);
    first_reg = f;
    last_reg  = l;
    rx_cnt    = 0;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("hdr_latency_valid", tx_valid, 1);
    check("hdr_latency_data", tx_data, 8'hA5);
    check("busy_after_start", busy, 1);
  endtask

  // mode 1: mid-dump regfile writes; mode 2: start pulse while in DATA.
  task automatic wait_done(input int mode, input int exp_bytes);
    bit seen  = 1'b0;
    bit poked = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (mode == 1 && !poked && rf_ra == 3'd5 && tx_valid) begin
        rf[5] = 32'hBADBAD55;
        rf[6] = 32'h66006600;
        poked = 1'b1;
      end
      if (mode == 2 && !poked && rx_cnt == 2 && tx_valid) begin
        first_reg = 3'd5;
        last_reg  = 3'd6;
        start     = 1'b1;
        poked     = 1'b1;
      end
      step();
      start = 1'b0;
      seen  = done;
    end
    check("done_seen", seen, 1);
    check("byte_count", rx_cnt, exp_bytes);
    check("queue_empty", exp_q.size(), 0);
    check("busy_low_at_done", busy, 0);
    step();
    check("done_single_cycle", done, 0);
  endtask

  // Stream monitor: outputs are stable at the falling edge, and a transfer
  // seen here happens at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, hold_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $error("FAIL extra_byte: observed %0h expected none", tx_data);
        end else begin
          check("stream_byte", tx_data, exp_q.pop_front());
        end
        rx_cnt++;
      end
      hold_prev = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  initial begin
    logic [31:0] img [8];
    bit          saw_done;

    rst       = 1'b1;
    start     = 1'b0;
    tx_ready  = 1'b1;
    first_reg = 3'd0;
    last_reg  = 3'd0;
    for (int i = 0; i < 8; i++) rf[i] = 32'h01020304 * (i + 1);
    rf[0] = 32'hFFFFFFFF;
    rf[1] = 32'h11223344;
    rf[2] = 32'hDEADBEEF;
    rf[7] = 32'h00000080;

    repeat (3) step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rf_ra", rf_ra, 0);
    rst = 1'b0;
    step();

    // Basic dump r1..r2 with the sink always ready.
    push_dump(3'd1, 3'd2, rf);
    start_dump(3'd1, 3'd2);
    wait_done(0, 10);

    // Same dump under random backpressure.
    rnd_ready = 1'b1;
    push_dump(3'd1, 3'd2, rf);
    start_dump(3'd1, 3'd2);
    wait_done(0, 10);

    // Wrapping range 7..0, r0 reads as zero.
    push_dump(3'd7, 3'd0, rf);
    start_dump(3'd7, 3'd0);
    wait_done(0, 10);

    // Full dump: r5 written after its LOAD keeps old bytes, r6 takes the new value.
    rnd_ready = 1'b0;
    img = rf;
    img[6] = 32'h66006600;
    push_dump(3'd0, 3'd7, img);
    start_dump(3'd0, 3'd7);
    wait_done(1, 34);

    // Start while busy is ignored.
    push_dump(3'd1, 3'd2, rf);
    start_dump(3'd1, 3'd2);
    wait_done(2, 10);

    // Reset during the third data byte aborts without a done pulse.
    push_dump(3'd1, 3'd2, rf);
    start_dump(3'd1, 3'd2);
    for (int i = 0; i < 50 && rx_cnt < 3; i++) step();
    check("bytes_before_rst", rx_cnt, 3);
    check("valid_before_rst", tx_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_no_bytes", rx_cnt, 3);

    // Fresh dump after the abort restarts header and checksum.
    push_dump(3'd1, 3'd2, rf);
    start_dump(3'd1, 3'd2);
    wait_done(0, 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
